uxa_ps2_busctl_mc: RTL and testbench

UXA_PS2_BUSCTL_MC -- requirements
Module: uxa_ps2_busctl_mc

---
 rtl/uxa_ps2_pkg.sv | 35 +++
 rtl/uxa_ps2_chan_ctl.sv | 37 +++
 rtl/uxa_ps2_busctl_mc.sv | 122 ++++++++++++
 tb/tb_uxa_ps2_busctl_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uxa_ps2_pkg.sv
// Shared definitions for the PS/2 bus controller: FSM encoding, data-word bit
// positions and the read-word formatter.
package uxa_ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int MAX_CHANNELS = 4;
    localparam int CNT_W        = 3;

    localparam int DAT_LSB   = 0;
    localparam int DAT_MSB   = 7;
    localparam int BIT_D     = 8;
    localparam int BIT_C     = 9;
    localparam int BIT_NOPOP = 15;
    localparam int BIT_EMPTY = 15;

    // Line bits read back as the level the pull-down allows (released = 1).
    function automatic logic [15:0] rd_word(input logic [7:0] q,
                                            input logic       c_oe,
                                            input logic       d_oe,
                                            input logic       empty);
        logic [15:0] w;
        w                  = '0;
        w[DAT_MSB:DAT_LSB] = q;
        w[BIT_D]           = ~d_oe;
        w[BIT_C]           = ~c_oe;
        w[BIT_EMPTY]       = empty;
        return w;
    endfunction

endpackage

// File: rtl/uxa_ps2_chan_ctl.sv
// Per-channel line-drive and FIFO-pop registers; updated by the write strobe
// generated in the ACK cycle of the bus controller.
module uxa_ps2_chan_ctl
    import uxa_ps2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr_i,
    input  logic c_bit_i,
    input  logic d_bit_i,
    input  logic pop_i,
    output logic c_oe_o,
    output logic d_oe_o,
    output logic rp_inc_o
);

    logic c_oe_q, d_oe_q, rp_inc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            rp_inc_q <= 1'b0;
        end else begin
            rp_inc_q <= pop_i;
            if (wr_i) begin
                c_oe_q <= ~c_bit_i;
                d_oe_q <= ~d_bit_i;
            end
        end
    end

    assign c_oe_o   = c_oe_q;
    assign d_oe_o   = d_oe_q;
    assign rp_inc_o = rp_inc_q;

endmodule

// File: rtl/uxa_ps2_busctl_mc.sv
// Wishbone slave fronting CHANNELS PS/2 ports: IDLE/WAIT/ACK handshake,
// per-channel line control and FIFO pop, registered read mux.
module uxa_ps2_busctl_mc
    import uxa_ps2_pkg::*;
#(
    parameter  int CHANNELS    = 2,
    parameter  int WAIT_STATES = 1,
    localparam int AW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_reset_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [AW-1:0]         wb_adr_i,
    input  logic [15:0]           wb_dat_i,
    output logic [15:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [8*CHANNELS-1:0] fifo_q_i,
    input  logic [CHANNELS-1:0]   fifo_empty_i,
    output logic [CHANNELS-1:0]   rp_inc_o,
    output logic [CHANNELS-1:0]   c_oe_o,
    output logic [CHANNELS-1:0]   d_oe_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    adr_q;
    logic             we_q, c_bit_q, d_bit_q, nopop_q, ack_q;
    logic [15:0]      dat_o_q;
    logic [15:0]      rd_d;
    logic [AW-1:0]    rd_adr;
    logic             req;
    logic             unused_dat;

    assign req        = wb_cyc_i & wb_stb_i;
    assign unused_dat = ^{wb_dat_i[14:10], wb_dat_i[7:0]};

    // With no wait states the read is captured straight out of IDLE, before
    // the address register has been loaded.
    assign rd_adr = (state_q == ST_IDLE) ? wb_adr_i : adr_q;

    // Addresses beyond CHANNELS match no channel and so read as zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_adr == AW'(i))
                rd_d = rd_word(fifo_q_i[8*i +: 8], c_oe_o[i], d_oe_o[i], fifo_empty_i[i]);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            c_bit_q <= 1'b0;
            d_bit_q <= 1'b0;
            nopop_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        adr_q   <= wb_adr_i;
                        we_q    <= wb_we_i;
                        c_bit_q <= wb_dat_i[BIT_C];
                        d_bit_q <= wb_dat_i[BIT_D];
                        nopop_q <= wb_dat_i[BIT_NOPOP];
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_ACK;
                            ack_q   <= 1'b1;
                            if (!wb_we_i) dat_o_q <= rd_d;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        if (!we_q) dat_o_q <= rd_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_o_q;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic wr, pop;
        assign wr  = ack_q & we_q & (adr_q == AW'(n));
        assign pop = wr & ~nopop_q & ~fifo_empty_i[n];

        uxa_ps2_chan_ctl u_chan (
            .clk_i    (sys_clk_i),
            .rst_i    (sys_reset_i),
            .wr_i     (wr),
            .c_bit_i  (c_bit_q),
            .d_bit_i  (d_bit_q),
            .pop_i    (pop),
            .c_oe_o   (c_oe_o[n]),
            .d_oe_o   (d_oe_o[n]),
            .rp_inc_o (rp_inc_o[n])
        );
    end

endmodule

// File: tb/tb_uxa_ps2_busctl_mc.sv
// Scoreboard bench for three controller configurations: (2 ch, 1 ws),
// (3 ch, 3 ws) and (2 ch, 0 ws).
module tb_uxa_ps2_busctl_mc;

    typedef struct {
        logic [15:0] val;
        bit          chk;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc_n = 0;
    int   checks = 0;
    int   failures = 0;

    logic [2:0]       cyc, stb, we;
    logic [2:0][1:0]  adr;
    logic [2:0][15:0] wdat;
    logic [2:0][23:0] fq;
    logic [2:0][2:0]  fe;

    logic [2:0][15:0] dat_w;
    logic [2:0]       ack_w;
    logic [2:0][2:0]  rp_w, c_w, d_w;
    logic [1:0]       a_rp, a_c, a_d, c_rp, c_c, c_d;

    exp_t ackq[3][$];
    exp_t popq[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    uxa_ps2_busctl_mc #(.CHANNELS(2), .WAIT_STATES(1)) u_a (
        .sys_clk_i(clk), .sys_reset_i(rst),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0][0:0]), .wb_dat_i(wdat[0]),
        .wb_dat_o(dat_w[0]), .wb_ack_o(ack_w[0]),
        .fifo_q_i(fq[0][15:0]), .fifo_empty_i(fe[0][1:0]),
        .rp_inc_o(a_rp), .c_oe_o(a_c), .d_oe_o(a_d));

    uxa_ps2_busctl_mc #(.CHANNELS(3), .WAIT_STATES(3)) u_b (
        .sys_clk_i(clk), .sys_reset_i(rst),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
        .wb_dat_o(dat_w[1]), .wb_ack_o(ack_w[1]),
        .fifo_q_i(fq[1]), .fifo_empty_i(fe[1]),
        .rp_inc_o(rp_w[1]), .c_oe_o(c_w[1]), .d_oe_o(d_w[1]));

    uxa_ps2_busctl_mc #(.CHANNELS(2), .WAIT_STATES(0)) u_c (
        .sys_clk_i(clk), .sys_reset_i(rst),
        .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
        .wb_adr_i(adr[2][0:0]), .wb_dat_i(wdat[2]),
        .wb_dat_o(dat_w[2]), .wb_ack_o(ack_w[2]),
        .fifo_q_i(fq[2][15:0]), .fifo_empty_i(fe[2][1:0]),
        .rp_inc_o(c_rp), .c_oe_o(c_c), .d_oe_o(c_d));

    assign rp_w[0] = {1'b0, a_rp};
    assign c_w[0]  = {1'b0, a_c};
    assign d_w[0]  = {1'b0, a_d};
    assign rp_w[2] = {1'b0, c_rp};
    assign c_w[2]  = {1'b0, c_c};
    assign d_w[2]  = {1'b0, c_d};

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc_n, act, exp);
        end
    endtask

    task automatic chk_idle(input int d);
        chk("rst_ack", d, 32'(ack_w[d]), 0);
        chk("rst_dat", d, 32'(dat_w[d]), 0);
        chk("rst_rp", d, 32'(rp_w[d]), 0);
        chk("rst_c_oe", d, 32'(c_w[d]), 0);
        chk("rst_d_oe", d, 32'(d_w[d]), 0);
    endtask

    // Monitor: every ack / pop pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (ack_w[d]) begin
                if (ackq[d].size() == 0) chk("ack_unexpected", d, 32'(ack_w[d]), 0);
                else begin
                    e = ackq[d].pop_front();
                    chk("ack_cycle", d, cyc_n, e.cyc);
                    if (e.chk) chk("rd_data", d, 32'(dat_w[d]), 32'(e.val));
                end
            end
            if (rp_w[d] != 3'b000) begin
                chk("pop_onehot", d, 32'($onehot(rp_w[d])), 1);
                if (popq[d].size() == 0) chk("pop_unexpected", d, 32'(rp_w[d]), 0);
                else begin
                    e = popq[d].pop_front();
                    chk("pop_cycle", d, cyc_n, e.cyc);
                    chk("pop_vec", d, 32'(rp_w[d]), 32'(e.val[2:0]));
                end
            end
        end
    end

    task automatic xact(input int d, input logic [1:0] a, input logic w, input logic [15:0] dat,
                        input logic [15:0] exp_rd, input bit do_chk, input logic [2:0] pop_vec);
        int p;
        bit seen;
        @(posedge clk); #1;
        p = cyc_n;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dat;
        ackq[d].push_back('{exp_rd, do_chk, p + 1 + ws_of(d)});
        if (pop_vec != 3'b000) popq[d].push_back('{16'(pop_vec), 1'b1, p + 2 + ws_of(d)});
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = ack_w[d];
        end
        chk("ack_seen", d, 32'(seen), 1);
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        rst = 1'b1;
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; fq = '0; fe = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle(d);
        @(posedge clk); #1;
        rst = 1'b0;

        // Config A: 2 channels, 1 wait state
        fq[0] = 24'h003CA5;
        fe[0] = 3'b000;
        xact(0, 2'd1, 1'b1, 16'h0000, 16'h0, 1'b0, 3'b010);
        chk("c_oe", 0, 32'(c_w[0]), 32'h2);
        chk("d_oe", 0, 32'(d_w[0]), 32'h2);
        xact(0, 2'd0, 1'b0, 16'h0000, 16'h03A5, 1'b1, 3'b000);
        fe[0] = 3'b010;
        xact(0, 2'd1, 1'b0, 16'h0000, 16'h803C, 1'b1, 3'b000);
        fe[0] = 3'b001;
        xact(0, 2'd0, 1'b1, 16'h0300, 16'h0, 1'b0, 3'b000);
        chk("c_oe", 0, 32'(c_w[0]), 32'h2);
        chk("d_oe", 0, 32'(d_w[0]), 32'h2);
        fe[0] = 3'b000;
        xact(0, 2'd0, 1'b1, 16'h8300, 16'h0, 1'b0, 3'b000);
        xact(0, 2'd0, 1'b1, 16'h0100, 16'h0, 1'b0, 3'b001);
        chk("c_oe", 0, 32'(c_w[0]), 32'h3);
        chk("d_oe", 0, 32'(d_w[0]), 32'h2);
        xact(0, 2'd0, 1'b0, 16'h0000, 16'h01A5, 1'b1, 3'b000);

        // Reset lands on the edge that would have entered ACK
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 2'd1; wdat[0] = 16'h0000;
        @(posedge clk); #1;
        chk("pre_rst_c_oe", 0, 32'(c_w[0]), 32'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        chk_idle(0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);

        // Config B: 3 channels, 3 wait states
        fq[1] = 24'h5A1234;
        fe[1] = 3'b100;
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 2'd0; wdat[1] = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_c_oe", 1, 32'(c_w[1]), 0);
        chk("abort_d_oe", 1, 32'(d_w[1]), 0);
        xact(1, 2'd2, 1'b0, 16'h0000, 16'h835A, 1'b1, 3'b000);
        xact(1, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'b000);
        fe[1] = 3'b000;
        xact(1, 2'd3, 1'b1, 16'h0000, 16'h0, 1'b0, 3'b000);
        chk("badadr_c_oe", 1, 32'(c_w[1]), 0);
        chk("badadr_d_oe", 1, 32'(d_w[1]), 0);
        xact(1, 2'd2, 1'b1, 16'h0200, 16'h0, 1'b0, 3'b100);
        chk("c_oe", 1, 32'(c_w[1]), 0);
        chk("d_oe", 1, 32'(d_w[1]), 32'h4);

        // Config C: 0 wait states, strobe held for three writes
        fe[2] = 3'b000;
        @(posedge clk); #1;
        p = cyc_n;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 2'd0; wdat[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            ackq[2].push_back('{16'h0, 1'b0, p + 1 + 2 * k});
            popq[2].push_back('{16'h0001, 1'b1, p + 2 + 2 * k});
        end
        repeat (6) @(posedge clk);
        #1;
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("c_oe", 2, 32'(c_w[2]), 32'h1);
        chk("d_oe", 2, 32'(d_w[2]), 32'h1);

        repeat (5) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("ack_missing", d, 32'(ackq[d].size()), 0);
            chk("pop_missing", d, 32'(popq[d].size()), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
